// File: rtl/tile_seq_ctrl.sv
// Diagonal-wavefront sequencer for a ROWS x COLS PE tile: FILL ramps enables in along
// anti-diagonals, RUN holds the full active region for len cycles, DRAIN ramps them out.
module tile_seq_ctrl #(
  parameter int ROWS  = 5,
  parameter int COLS  = 5,
  parameter int LEN_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_start,
  input  logic                   i_abort,
  input  logic                   i_stall,
  input  logic [1:0]             i_cal_state,
  input  logic [2:0]             i_layer_state,
  input  logic [LEN_W-1:0]       i_len,
  output logic [ROWS*COLS-1:0]   pe_en,
  output logic [ROWS+COLS-2:0]   mul_en,
  output logic [ROWS-1:0]        str_en,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_err
);

  localparam int NPE = ROWS * COLS;
  localparam int NDG = ROWS + COLS - 1;
  localparam int KW  = $clog2(NDG + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FILL  = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t           state;
  logic [KW-1:0]    k;
  logic [LEN_W-1:0] run_cnt;
  logic             conv_q;
  logic             part_q;
  logic [LEN_W-1:0] len_q;

  logic [KW-1:0]    ar;
  logic [KW-1:0]    ac;
  logic [KW-1:0]    nd;
  logic             layer_ok;
  logic             start_ok;
  logic [NPE-1:0]   pe_nxt;
  logic [NDG-1:0]   mul_nxt;
  logic [ROWS-1:0]  str_nxt;

  // Odd layer codes are convolutions (all rows); even codes are subsampling (last row idle).
  always_comb begin
    case (i_layer_state)
      3'b001, 3'b010, 3'b011, 3'b100, 3'b101: layer_ok = 1'b1;
      default:                                layer_ok = 1'b0;
    endcase
    start_ok = (i_cal_state != 2'b00) && layer_ok;
    ar = conv_q ? KW'(ROWS) : KW'(ROWS - 1);
    ac = part_q ? KW'(1) : KW'(COLS);
    nd = ar + ac - KW'(1);
  end

  always_comb begin
    pe_nxt  = '0;
    mul_nxt = '0;
    str_nxt = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if (r < int'(ar) && c < int'(ac)) begin
          case (state)
            S_FILL:  pe_nxt[r*COLS+c] = (r + c <= int'(k));
            S_RUN:   pe_nxt[r*COLS+c] = 1'b1;
            S_DRAIN: pe_nxt[r*COLS+c] = (r + c > int'(k));
            default: pe_nxt[r*COLS+c] = 1'b0;
          endcase
        end
      end
    end
    for (int d = 0; d < NDG; d++) begin
      if (d < int'(nd)) begin
        case (state)
          S_FILL:  mul_nxt[d] = (d <= int'(k));
          S_RUN:   mul_nxt[d] = 1'b1;
          S_DRAIN: mul_nxt[d] = (d > int'(k));
          default: mul_nxt[d] = 1'b0;
        endcase
      end
    end
    // A row can store once its last active column's diagonal has been reached.
    for (int r = 0; r < ROWS; r++) begin
      if (r < int'(ar)) begin
        case (state)
          S_FILL:  str_nxt[r] = (r + int'(ac) - 1 <= int'(k));
          S_RUN:   str_nxt[r] = 1'b1;
          S_DRAIN: str_nxt[r] = (r + int'(ac) - 1 > int'(k));
          default: str_nxt[r] = 1'b0;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      k       <= '0;
      run_cnt <= '0;
      conv_q  <= 1'b0;
      part_q  <= 1'b0;
      len_q   <= '0;
      pe_en   <= '0;
      mul_en  <= '0;
      str_en  <= '0;
      o_busy  <= 1'b0;
      o_done  <= 1'b0;
      o_err   <= 1'b0;
    end else begin
      pe_en  <= i_stall ? '0 : pe_nxt;
      mul_en <= i_stall ? '0 : mul_nxt;
      str_en <= i_stall ? '0 : str_nxt;
      o_busy <= (state != S_IDLE);
      // A stalled DONE holds; the pulse fires on the cycle it actually retires.
      o_done <= (state == S_DONE) && !i_stall && !i_abort;
      o_err  <= 1'b0;

      if (state != S_IDLE && i_abort) begin
        state   <= S_IDLE;
        k       <= '0;
        run_cnt <= '0;
      end else if (state != S_IDLE && i_stall) begin
        state <= state;
      end else begin
        case (state)
          S_IDLE: begin
            if (i_start) begin
              if (start_ok) begin
                conv_q  <= i_layer_state[0];
                part_q  <= (i_cal_state == 2'b10);
                len_q   <= i_len;
                k       <= '0;
                run_cnt <= '0;
                state   <= S_FILL;
              end else begin
                o_err <= 1'b1;
              end
            end
          end
          S_FILL: begin
            if (k == nd - KW'(1)) begin
              k       <= '0;
              run_cnt <= '0;
              state   <= (len_q == '0) ? S_DRAIN : S_RUN;
            end else begin
              k <= k + KW'(1);
            end
          end
          S_RUN: begin
            if (run_cnt == len_q - LEN_W'(1)) begin
              k     <= '0;
              state <= S_DRAIN;
            end else begin
              run_cnt <= run_cnt + LEN_W'(1);
            end
          end
          S_DRAIN: begin
            if (k == nd - KW'(1)) begin
              k     <= '0;
              state <= S_DONE;
            end else begin
              k <= k + KW'(1);
            end
          end
          S_DONE:  state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tile_seq_ctrl.sv
// Scoreboard bench for tile_seq_ctrl: drivers queue the per-cycle output trace of each
// sequence; a negedge monitor pops and compares whenever the DUT is busy or pulsing.
module tb_tile_seq_ctrl;

  localparam int ROWS  = 5;
  localparam int COLS  = 5;
  localparam int LEN_W = 16;
  localparam int NPE   = ROWS * COLS;
  localparam int NDG   = ROWS + COLS - 1;
  localparam int W     = NPE + NDG + ROWS + 3;
  localparam int PH_FILL  = 0;
  localparam int PH_DRAIN = 1;

  logic                 clk;
  logic                 rst_n;
  logic                 i_start;
  logic                 i_abort;
  logic                 i_stall;
  logic [1:0]           i_cal_state;
  logic [2:0]           i_layer_state;
  logic [LEN_W-1:0]     i_len;
  logic [NPE-1:0]       pe_en;
  logic [NDG-1:0]       mul_en;
  logic [ROWS-1:0]      str_en;
  logic                 o_busy;
  logic                 o_done;
  logic                 o_err;

  logic [W-1:0] exp_q[$];
  int           checks;
  int           errors;
  string        cur_test;

  tile_seq_ctrl #(.ROWS(ROWS), .COLS(COLS), .LEN_W(LEN_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_start       (i_start),
    .i_abort       (i_abort),
    .i_stall       (i_stall),
    .i_cal_state   (i_cal_state),
    .i_layer_state (i_layer_state),
    .i_len         (i_len),
    .pe_en         (pe_en),
    .mul_en        (mul_en),
    .str_en        (str_en),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_err         (o_err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] pack_exp(logic [NPE-1:0] pe, logic [NDG-1:0] mul,
                                            logic [ROWS-1:0] str, logic busy, logic done,
                                            logic err);
    return {pe, mul, str, busy, done, err};
  endfunction

  // Enables of one FILL or DRAIN step, built from the active rectangle ar x ac.
  function automatic logic [W-1:0] model_step(int phase, int ar, int ac, int k);
    logic [NPE-1:0]  pe  = '0;
    logic [NDG-1:0]  mul = '0;
    logic [ROWS-1:0] str = '0;
    int nd = ar + ac - 1;
    for (int r = 0; r < ar; r++)
      for (int c = 0; c < ac; c++)
        pe[r*COLS+c] = (phase == PH_FILL) ? (r + c <= k) : (r + c > k);
    for (int d = 0; d < nd; d++)
      mul[d] = (phase == PH_FILL) ? (d <= k) : (d > k);
    for (int r = 0; r < ar; r++)
      str[r] = (phase == PH_FILL) ? (r + ac - 1 <= k) : (r + ac - 1 > k);
    return pack_exp(pe, mul, str, 1'b1, 1'b0, 1'b0);
  endfunction

  // Expected trace of one accepted sequence; run_cut >= 0 ends it after that RUN cycle.
  task automatic push_seq(int ar, int ac, int len, logic [NPE-1:0] rpe, logic [NDG-1:0] rmul,
                          logic [ROWS-1:0] rstr, int stall_k, int stall_n, int run_cut);
    int nd = ar + ac - 1;
    for (int k = 0; k < nd; k++) begin
      if (k == stall_k)
        for (int s = 0; s < stall_n; s++) exp_q.push_back(pack_exp('0, '0, '0, 1'b1, 1'b0, 1'b0));
      exp_q.push_back(model_step(PH_FILL, ar, ac, k));
    end
    for (int i = 0; i < len; i++) begin
      exp_q.push_back(pack_exp(rpe, rmul, rstr, 1'b1, 1'b0, 1'b0));
      if (i == run_cut) return;
    end
    for (int k = 0; k < nd; k++) exp_q.push_back(model_step(PH_DRAIN, ar, ac, k));
    exp_q.push_back(pack_exp('0, '0, '0, 1'b1, 1'b1, 1'b0));
  endtask

  task automatic check_drained();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s missing outputs: got %0d unconsumed, required 0", cur_test, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic idle_inputs();
    i_start       = 1'b0;
    i_abort       = 1'b0;
    i_stall       = 1'b0;
    i_cal_state   = 2'b00;
    i_layer_state = 3'b000;
    i_len         = '0;
  endtask

  // Drives one sequence from a negedge; cycle cyc sets the inputs seen at edge E_cyc.
  task automatic drive_seq(string name, logic [1:0] cal, logic [2:0] layer, int len, int nd,
                           int stall_k, int stall_n, int abort_cut, bit start_in_done);
    int done_edge = 2 * nd + len + stall_n + 1;
    int total     = done_edge + 5;
    cur_test = name;
    for (int cyc = 0; cyc < total; cyc++) begin
      if (cyc == 0) begin
        i_cal_state   = cal;
        i_layer_state = layer;
        i_len         = LEN_W'(len);
        i_start       = 1'b1;
      end else if (start_in_done && cyc == done_edge) begin
        i_cal_state   = 2'b01;
        i_layer_state = 3'b001;
        i_len         = LEN_W'(3);
        i_start       = 1'b1;
      end else begin
        i_cal_state   = 2'b00;
        i_layer_state = 3'b111;
        i_len         = LEN_W'(16'h00f7);
        i_start       = 1'b0;
      end
      i_stall = (stall_k >= 0) && (cyc >= stall_k + 1) && (cyc < stall_k + 1 + stall_n);
      i_abort = (abort_cut >= 0) && (cyc == nd + 1 + abort_cut);
      @(negedge clk);
    end
    idle_inputs();
    check_drained();
  endtask

  task automatic drive_reject(string name, logic [1:0] cal, logic [2:0] layer);
    cur_test = name;
    exp_q.push_back(pack_exp('0, '0, '0, 1'b0, 1'b0, 1'b1));
    i_cal_state   = cal;
    i_layer_state = layer;
    i_len         = LEN_W'(4);
    i_start       = 1'b1;
    @(negedge clk);
    idle_inputs();
    repeat (4) @(negedge clk);
    check_drained();
  endtask

  task automatic check_all_zero(string name);
    checks++;
    if ({pe_en, mul_en, str_en, o_busy, o_done, o_err} !== '0) begin
      errors++;
      $display("FAIL %s got=%h required=0", name, {pe_en, mul_en, str_en, o_busy, o_done, o_err});
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [W-1:0] got;
    logic [W-1:0] exp;
    if (rst_n && (o_busy || o_done || o_err)) begin
      got = {pe_en, mul_en, str_en, o_busy, o_done, o_err};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL %s unexpected output got=%h required=none", cur_test, got);
      end else begin
        exp = exp_q.pop_front();
        if (got !== exp) begin
          errors++;
          $display("FAIL %s trace got=%h required=%h", cur_test, got, exp);
        end
      end
    end
  end

  initial begin
    checks   = 0;
    errors   = 0;
    cur_test = "reset";
    rst_n    = 1'b0;
    idle_inputs();
    #1;
    check_all_zero("reset_state");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    push_seq(5, 5, 3, 25'h1ffffff, 9'h1ff, 5'h1f, -1, 0, -1);
    drive_seq("full_c1_len3", 2'b01, 3'b001, 3, 9, -1, 0, -1, 1'b1);

    push_seq(4, 5, 2, 25'h00fffff, 9'h0ff, 5'h0f, -1, 0, -1);
    drive_seq("full_s2_len2", 2'b01, 3'b010, 2, 8, -1, 0, -1, 1'b0);

    push_seq(5, 1, 1, 25'h0108421, 9'h01f, 5'h1f, -1, 0, -1);
    drive_seq("part_c3_len1", 2'b10, 3'b011, 1, 5, -1, 0, -1, 1'b0);

    push_seq(5, 5, 0, '0, '0, '0, -1, 0, -1);
    drive_seq("full_c5_len0", 2'b01, 3'b101, 0, 9, -1, 0, -1, 1'b0);

    push_seq(5, 5, 2, 25'h1ffffff, 9'h1ff, 5'h1f, 3, 4, -1);
    drive_seq("stall_fill_k3", 2'b01, 3'b001, 2, 9, 3, 4, -1, 1'b0);

    push_seq(5, 5, 5, 25'h1ffffff, 9'h1ff, 5'h1f, -1, 0, 0);
    drive_seq("abort_run", 2'b01, 3'b001, 5, 9, -1, 0, 0, 1'b0);

    drive_reject("reject_cal00", 2'b00, 3'b001);
    drive_reject("reject_layer000", 2'b01, 3'b000);
    drive_reject("reject_layer110", 2'b10, 3'b110);
    drive_reject("reject_layer111", 2'b01, 3'b111);

    // Reset in FILL k=3 of a PART/S4 sequence, then restart on the first edge after release.
    cur_test = "reset_mid";
    for (int k = 0; k < 3; k++) exp_q.push_back(model_step(PH_FILL, 4, 1, k));
    for (int cyc = 0; cyc < 4; cyc++) begin
      i_cal_state   = 2'b10;
      i_layer_state = 3'b100;
      i_len         = LEN_W'(2);
      i_start       = (cyc == 0);
      @(negedge clk);
    end
    idle_inputs();
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("reset_mid_outputs");
    check_drained();
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    push_seq(4, 1, 2, 25'h0008421, 9'h00f, 5'h0f, -1, 0, -1);
    drive_seq("restart_part_s4", 2'b10, 3'b100, 2, 4, -1, 0, -1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
